id_issue_stage: RTL and testbench

//  Parametrised decode-to-execute issue stage: resolves NSRC source operands
//  (EX > ME > WB > regfile forwarding), detects load-use hazards, and holds
//  the stage output register. Generalises the fixed 2-operand decode latch:
//  the interlock is generated internally, and the output uses valid/ready.

---
 rtl/id_issue_stage_if.sv | 29 ++
 rtl/id_issue_stage.sv | 122 ++++++++++++
 tb/tb_id_issue_stage.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_issue_stage_if.sv
// ID-to-EX issue bus: decoded instruction into the stage, registered instruction out to EX.
// master = decoder/EX side, slave = the issue stage.
interface id_issue_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned PAY_W  = 43
);
  logic                     in_valid;
  logic                     in_ready;
  logic [PAY_W-1:0]         in_payload;
  logic [NSRC*REG_AW-1:0]   in_src_addr;
  logic [NSRC-1:0]          in_src_used;
  logic [NSRC*DATA_W-1:0]   in_rf_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [PAY_W-1:0]         out_payload;
  logic [NSRC*DATA_W-1:0]   out_src_data;

  modport master (
    output in_valid, in_payload, in_src_addr, in_src_used, in_rf_data, out_ready,
    input  in_ready, out_valid, out_payload, out_src_data
  );

  modport slave (
    input  in_valid, in_payload, in_src_addr, in_src_used, in_rf_data, out_ready,
    output in_ready, out_valid, out_payload, out_src_data
  );
endinterface

// File: rtl/id_issue_stage.sv
// Decode-to-execute issue stage: operand forwarding (EX > ME > WB > regfile), load-use
// interlock and valid/ready output register. Optional stall counter under ID_STALL_CNT_EN.
module id_issue_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned NSRC   = 2,
    parameter int unsigned PAY_W  = 43
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    id_issue_stage_if.slave   bus,
    input  logic              ex_wen,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_load,
    input  logic              me_wen,
    input  logic [REG_AW-1:0] me_waddr,
    input  logic [DATA_W-1:0] me_wdata,
    input  logic              me_load_pend,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              hazard,
    output logic [31:0]       stall_cycles
);

    logic [NSRC*DATA_W-1:0] fwd_data;
    logic [REG_AW-1:0]      src_a;
    logic                   ex_hit;
    logic                   me_hit;
    logic                   wb_hit;
    logic                   issue;

    logic                   out_valid_q, out_valid_d;
    logic [PAY_W-1:0]       out_payload_q, out_payload_d;
    logic [NSRC*DATA_W-1:0] out_src_data_q, out_src_data_d;

    // r0 is hardwired zero: never forwarded and never a hazard source
    always_comb begin
        fwd_data = '0;
        hazard   = 1'b0;
        src_a    = '0;
        ex_hit   = 1'b0;
        me_hit   = 1'b0;
        wb_hit   = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            src_a  = bus.in_src_addr[i*REG_AW +: REG_AW];
            ex_hit = ex_wen && (ex_waddr == src_a);
            me_hit = me_wen && (me_waddr == src_a);
            wb_hit = wb_wen && (wb_waddr == src_a);
            if (src_a != '0) begin
                if (ex_hit)
                    fwd_data[i*DATA_W +: DATA_W] = ex_wdata;
                else if (me_hit)
                    fwd_data[i*DATA_W +: DATA_W] = me_wdata;
                else if (wb_hit)
                    fwd_data[i*DATA_W +: DATA_W] = wb_wdata;
                else
                    fwd_data[i*DATA_W +: DATA_W] = bus.in_rf_data[i*DATA_W +: DATA_W];
                if (bus.in_src_used[i] && ((ex_hit && ex_load) || (me_hit && me_load_pend)))
                    hazard = 1'b1;
            end
        end
    end

    assign issue        = bus.in_valid && !hazard && !flush && (!out_valid_q || bus.out_ready);
    assign bus.in_ready = issue;

    always_comb begin
        out_valid_d    = out_valid_q;
        out_payload_d  = out_payload_q;
        out_src_data_d = out_src_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d    = 1'b1;
            out_payload_d  = bus.in_payload;
            out_src_data_d = fwd_data;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_q    <= 1'b0;
            out_payload_q  <= '0;
            out_src_data_q <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_payload_q  <= out_payload_d;
            out_src_data_q <= out_src_data_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_payload  = out_payload_q;
    assign bus.out_src_data = out_src_data_q;

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (bus.in_valid && hazard && !flush)
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            stall_cycles_q <= '0;
        else
            stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_id_issue_stage.sv
// Scoreboard bench for id_issue_stage: directed forwarding/hazard/backpressure cases
// followed by randomized traffic, checked against a rule-level reference model.
`timescale 1ns/1ps
module tb_id_issue_stage;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NSRC   = 2;
    localparam int unsigned PAY_W  = 43;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              flush = 1'b0;
    logic              ex_wen = 1'b0, ex_load = 1'b0;
    logic [REG_AW-1:0] ex_waddr = '0;
    logic [DATA_W-1:0] ex_wdata = '0;
    logic              me_wen = 1'b0, me_load_pend = 1'b0;
    logic [REG_AW-1:0] me_waddr = '0;
    logic [DATA_W-1:0] me_wdata = '0;
    logic              wb_wen = 1'b0;
    logic [REG_AW-1:0] wb_waddr = '0;
    logic [DATA_W-1:0] wb_wdata = '0;
    logic              hazard;
    logic [31:0]       stall_cycles;

    id_issue_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NSRC(NSRC), .PAY_W(PAY_W)) bus ();

    id_issue_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NSRC(NSRC), .PAY_W(PAY_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .bus(bus),
        .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_load(ex_load),
        .me_wen(me_wen), .me_waddr(me_waddr), .me_wdata(me_wdata), .me_load_pend(me_load_pend),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .hazard(hazard), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PAY_W-1:0]       pay;
        logic [NSRC*DATA_W-1:0] data;
    } item_t;

    item_t             exp_q[$];
    int unsigned       total = 0;
    int unsigned       bad = 0;
    logic              m_valid = 1'b0;
    logic [31:0]       m_cnt = '0;

    // stimulus per source, packed onto the bus by apply()
    logic [REG_AW-1:0] s_addr[NSRC];
    logic              s_used[NSRC];
    logic [DATA_W-1:0] s_rf[NSRC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_operand(input int unsigned i);
        logic [REG_AW-1:0] a;
        a = s_addr[i];
        if (a == 0) return '0;
        if (ex_wen && ex_waddr == a) return ex_wdata;
        if (me_wen && me_waddr == a) return me_wdata;
        if (wb_wen && wb_waddr == a) return wb_wdata;
        return s_rf[i];
    endfunction

    function automatic logic ref_hazard();
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (s_used[i] && s_addr[i] != 0) begin
                if (ex_wen && ex_waddr == s_addr[i] && ex_load) return 1'b1;
                if (me_wen && me_waddr == s_addr[i] && me_load_pend) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic apply();
        for (int unsigned i = 0; i < NSRC; i++) begin
            bus.in_src_addr[i*REG_AW +: REG_AW] = s_addr[i];
            bus.in_src_used[i]                  = s_used[i];
            bus.in_rf_data[i*DATA_W +: DATA_W]  = s_rf[i];
        end
    endtask

    // One cycle: settle inputs, check combinational outputs, advance the model, clock.
    task automatic step();
        logic  exp_h, exp_r;
        item_t it;
        apply();
        #1;
        exp_h = ref_hazard();
        exp_r = bus.in_valid && !exp_h && !flush && (!m_valid || bus.out_ready);
        check("hazard", 64'(hazard), 64'(exp_h));
        check("in_ready", 64'(bus.in_ready), 64'(exp_r));
        check("out_valid", 64'(bus.out_valid), 64'(m_valid));
        check("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
        if (m_valid && !bus.out_ready && flush && exp_q.size() > 0)
            void'(exp_q.pop_front());
        if (exp_r) begin
            it.pay  = bus.in_payload;
            it.data = '0;
            for (int unsigned i = 0; i < NSRC; i++)
                it.data[i*DATA_W +: DATA_W] = ref_operand(i);
            exp_q.push_back(it);
        end
`ifdef ID_STALL_CNT_EN
        if (bus.in_valid && exp_h && !flush) m_cnt = m_cnt + 32'd1;
`endif
        if (flush)               m_valid = 1'b0;
        else if (exp_r)          m_valid = 1'b1;
        else if (bus.out_ready)  m_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.in_valid   = 1'b0;
        bus.in_payload = '0;
        bus.out_ready  = 1'b1;
        flush = 1'b0;
        ex_wen = 1'b0; ex_load = 1'b0; ex_waddr = '0; ex_wdata = '0;
        me_wen = 1'b0; me_load_pend = 1'b0; me_waddr = '0; me_wdata = '0;
        wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            s_addr[i] = '0; s_used[i] = 1'b0; s_rf[i] = '0;
        end
    endtask

    task automatic do_reset();
        quiet();
        bus.out_ready = 1'b0;
        apply();
        resetn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_q.delete();
        m_valid = 1'b0;
        m_cnt   = '0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_payload", 64'(bus.out_payload), 64'd0);
        check("rst_out_src_data", 64'(bus.out_src_data), 64'd0);
        check("rst_stall_cycles", 64'(stall_cycles), 64'd0);
        resetn = 1'b1;
    endtask

    // Monitor: every accepted output must match the oldest issued expectation.
    always @(posedge clk) begin
        item_t e;
        if (resetn && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got out_valid=1 want no pending instruction at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("out_payload", 64'(bus.out_payload), 64'(e.pay));
                check("out_src_data", 64'(bus.out_src_data), 64'(e.data));
            end
        end
    end

    initial begin
        logic [63:0] r64;
        do_reset();

        // forwarding priority on src0 = r5
        quiet();
        bus.in_valid = 1'b1; bus.in_payload = 43'h1;
        s_addr[0] = 5'd5; s_used[0] = 1'b1; s_rf[0] = 32'h44;
        ex_wen = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h11;
        me_wen = 1'b1; me_waddr = 5'd5; me_wdata = 32'h22;
        wb_wen = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h33;
        step();
        ex_wen = 1'b0; bus.in_payload = 43'h2; step();
        me_wen = 1'b0; bus.in_payload = 43'h3; step();
        wb_wen = 1'b0; bus.in_payload = 43'h4; step();

        // r0 reads zero even with an EX load targeting r0
        quiet();
        bus.in_valid = 1'b1; bus.in_payload = 43'h5;
        s_addr[0] = '0; s_used[0] = 1'b1; s_rf[0] = 32'hDEAD;
        ex_wen = 1'b1; ex_waddr = '0; ex_wdata = 32'hFF; ex_load = 1'b1;
        step();

        // load-use on src1 = r7, then ME forward
        quiet();
        bus.in_valid = 1'b1; bus.in_payload = 43'h6;
        s_addr[1] = 5'd7; s_used[1] = 1'b1; s_rf[1] = 32'h99;
        ex_wen = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'h1234; ex_load = 1'b1;
        step();
        ex_wen = 1'b0; ex_load = 1'b0;
        me_wen = 1'b1; me_waddr = 5'd7; me_wdata = 32'h77;
        step();

        // same load in EX but src1 unused: issues at once
        quiet();
        bus.in_valid = 1'b1; bus.in_payload = 43'h7;
        s_addr[1] = 5'd7; s_used[1] = 1'b0; s_rf[1] = 32'h99;
        ex_wen = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'h1234; ex_load = 1'b1;
        step();

        // backpressure hold, then flush during hold
        quiet();
        bus.in_valid = 1'b1; bus.in_payload = 43'h8; s_addr[0] = 5'd3; s_rf[0] = 32'h3;
        step();
        bus.out_ready = 1'b0; bus.in_payload = 43'h9;
        step(); step(); step();
        flush = 1'b1; step();
        flush = 1'b0; bus.in_valid = 1'b0; step();

        // four hazard cycles, one of them flushed
        quiet();
        bus.in_valid = 1'b1; bus.in_payload = 43'hA;
        s_addr[0] = 5'd9; s_used[0] = 1'b1;
        ex_wen = 1'b1; ex_waddr = 5'd9; ex_load = 1'b1;
        step(); step(); flush = 1'b1; step(); flush = 1'b0; step();
        bus.in_valid = 1'b0; ex_wen = 1'b0; ex_load = 1'b0;
        step();
`ifdef ID_STALL_CNT_EN
        check("stall_count_3", 64'(stall_cycles), 64'd3);
`else
        check("stall_count_off", 64'(stall_cycles), 64'd0);
`endif
        do_reset();

        // randomized traffic with a small register window to provoke matches
        for (int n = 0; n < 3000; n++) begin
            bus.in_valid = ($urandom_range(0, 9) < 8);
            r64 = {$urandom, $urandom};
            bus.in_payload = r64[PAY_W-1:0];
            for (int unsigned i = 0; i < NSRC; i++) begin
                s_addr[i] = REG_AW'($urandom_range(0, 3));
                s_used[i] = ($urandom_range(0, 3) != 0);
                s_rf[i]   = $urandom;
            end
            ex_wen = ($urandom_range(0, 1) == 1); ex_waddr = REG_AW'($urandom_range(0, 3));
            ex_wdata = $urandom; ex_load = ($urandom_range(0, 3) == 0);
            me_wen = ($urandom_range(0, 1) == 1); me_waddr = REG_AW'($urandom_range(0, 3));
            me_wdata = $urandom; me_load_pend = ($urandom_range(0, 3) == 0);
            wb_wen = ($urandom_range(0, 1) == 1); wb_waddr = REG_AW'($urandom_range(0, 3));
            wb_wdata = $urandom;
            flush = ($urandom_range(0, 15) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // drain: every issued instruction must have reached EX or been flushed
        quiet();
        step(); step(); step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
